// File: rtl/tbird_if.sv
// Switch-to-sequencer bundle: raw switch inputs in, debounced levels and lamp-step controls out.
interface tbird_if;
  logic L_RAW;
  logic B_RAW;
  logic R_RAW;
  logic HAZ_RAW;
  logic L;
  logic B;
  logic R;
  logic Emerg;
  logic STEP;
  logic Q0;
  logic Lite_1;
  logic Lite_2;
  logic Lite_3;

  modport master (
    output L_RAW, B_RAW, R_RAW, HAZ_RAW,
    input  L, B, R, Emerg, STEP, Q0, Lite_1, Lite_2, Lite_3
  );

  modport slave (
    input  L_RAW, B_RAW, R_RAW, HAZ_RAW,
    output L, B, R, Emerg, STEP, Q0, Lite_1, Lite_2, Lite_3
  );
endinterface

// File: rtl/tbird_sequencer.sv
// Thunderbird tail-light control stage: sync + debounce switches, step prescaler, phase sweep.
// Define TBIRD_HAZARD_EN to add the debounced hazard switch to Emerg.
module tbird_sequencer #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic   CLK100MHZ,
  input  logic   RST,
  tbird_if.slave io
);

`ifdef TBIRD_HAZARD_EN
  localparam int NCH = 4;
`else
  localparam int NCH = 3;
`endif
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    S3   = 2'd3
  } phase_t;

  // Channel order: 0 = L, 1 = B, 2 = R, 3 = HAZ (hazard build only)
  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1_q, sync1_d;
  logic [NCH-1:0] sync2_q, sync2_d;
  logic [NCH-1:0] db_q, db_d;
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];

  logic [PW-1:0]  presc_q, presc_d;
  logic           step_q, step_d;
  logic           q0_q, q0_d;
  phase_t         phase_q, phase_d;
  logic [2:0]     lite_q, lite_d;
  logic           l_prev_q, l_prev_d;
  logic           r_prev_q, r_prev_d;
  logic           emerg_prev_q, emerg_prev_d;

  logic           emerg;
  logic           active;
  logic           restart;

`ifdef TBIRD_HAZARD_EN
  assign raw   = {io.HAZ_RAW, io.R_RAW, io.B_RAW, io.L_RAW};
  assign emerg = db_q[3] | (db_q[0] & db_q[2]);
`else
  logic unused_haz;
  assign unused_haz = io.HAZ_RAW;
  assign raw   = {io.R_RAW, io.B_RAW, io.L_RAW};
  assign emerg = db_q[0] & db_q[2];
`endif

  // Input path: two-flop synchronizer, then per-channel debounce counter
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Any edge on a level that drives the sweep restarts it from a full step period
  assign restart = (db_q[0] != l_prev_q) | (db_q[2] != r_prev_q) | (emerg != emerg_prev_q);
  assign active  = db_q[0] | db_q[2] | emerg;

  always_comb begin
    l_prev_d     = db_q[0];
    r_prev_d     = db_q[2];
    emerg_prev_d = emerg;
    presc_d      = (restart || (presc_q == PRE_LAST)) ? '0 : presc_q + 1'b1;
    step_d       = (presc_d == PRE_LAST);
    q0_d         = q0_q ^ step_q;
    phase_d      = phase_q;
    if (restart || !active) begin
      phase_d = IDLE;
    end else if (step_q) begin
      case (phase_q)
        IDLE:    phase_d = S1;
        S1:      phase_d = S2;
        S2:      phase_d = S3;
        default: phase_d = IDLE;
      endcase
    end
    lite_d = {phase_d == S3, phase_d >= S2, phase_d != IDLE};
  end

  // State register stage
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      db_q         <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      presc_q      <= '0;
      step_q       <= 1'b0;
      q0_q         <= 1'b0;
      phase_q      <= IDLE;
      lite_q       <= '0;
      l_prev_q     <= 1'b0;
      r_prev_q     <= 1'b0;
      emerg_prev_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      db_q         <= db_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
      presc_q      <= presc_d;
      step_q       <= step_d;
      q0_q         <= q0_d;
      phase_q      <= phase_d;
      lite_q       <= lite_d;
      l_prev_q     <= l_prev_d;
      r_prev_q     <= r_prev_d;
      emerg_prev_q <= emerg_prev_d;
    end
  end

  assign io.L      = db_q[0];
  assign io.B      = db_q[1];
  assign io.R      = db_q[2];
  assign io.Emerg  = emerg;
  assign io.STEP   = step_q;
  assign io.Q0     = q0_q;
  assign io.Lite_1 = lite_q[0];
  assign io.Lite_2 = lite_q[1];
  assign io.Lite_3 = lite_q[2];

endmodule
